// File: rtl/hdmi_rx_channel.sv
// hdmi_rx_channel: one TMDS receive channel.
// Classifies and decodes 10-bit TMDS words and hunts for word alignment
// using runs of control tokens, pulsing rx_bitslip at the deserializer
// until a stable run pattern is seen.
// The stream has no backpressure: a word is accepted every rx_clk cycle
// and rx_dv alone qualifies rx_data.
// Optional feature: define HDMI_RX_SLIPCNT_EN to add the 16-bit saturating
// rx_slip_cnt output that counts rx_bitslip pulses.
module hdmi_rx_channel #(
    parameter int TIMEOUT   = 4096,
    parameter int RUN_LEN   = 8,
    parameter int LOCK_RUNS = 4,
    parameter int SLIP_WAIT = 16
) (
    input  logic        rx_clk,
    input  logic        rst,
    input  logic [9:0]  rx_raw,
    output logic        rx_bitslip,
    output logic [7:0]  rx_data,
    output logic [1:0]  rx_c,
    output logic        rx_dv,
    output logic        rx_locked,
`ifdef HDMI_RX_SLIPCNT_EN
    output logic [15:0] rx_slip_cnt,
`endif
    output logic [1:0]  dbg_state_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = $clog2(RUN_LEN + 1);
    localparam int LW = $clog2(LOCK_RUNS + 1);
    localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RUN_FULL  = RW'(RUN_LEN);
    localparam logic [RW-1:0] RUN_LAST  = RW'(RUN_LEN - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_RUNS - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Stage 1 registers
    logic [9:0] s1_raw_q;
    logic       s1_ctrl_q;
    logic [1:0] s1_cval_q;

    // Stage 2 (output) registers
    logic [7:0] data_q;
    logic [1:0] c_q;
    logic       dv_q;

    // Alignment counters
    logic [RW-1:0] run_q, run_d, run_next;
    logic [LW-1:0] lock_q, lock_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          run_event;

    // Combinational token classification of the incoming word
    logic       raw_ctrl;
    logic [1:0] raw_cval;
    logic [7:0] dec_q;

    // Classify rx_raw as one of the four control tokens or a data word
    always_comb begin
        raw_ctrl = 1'b1;
        raw_cval = 2'b00;
        case (rx_raw)
            10'b1101010100: raw_cval = 2'b00;
            10'b0010101011: raw_cval = 2'b01;
            10'b0101010100: raw_cval = 2'b10;
            10'b1010101011: raw_cval = 2'b11;
            default:        raw_ctrl = 1'b0;
        endcase
    end

    // Stage 1: capture the raw word together with its classification
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            s1_raw_q  <= 10'd0;
            s1_ctrl_q <= 1'b0;
            s1_cval_q <= 2'b00;
        end else begin
            s1_raw_q  <= rx_raw;
            s1_ctrl_q <= raw_ctrl;
            s1_cval_q <= raw_cval;
        end
    end

    // TMDS data decode of the stage-1 word (undo inversion, then XOR/XNOR chain)
    always_comb begin
        logic [7:0] d;
        d        = s1_raw_q[9] ? ~s1_raw_q[7:0] : s1_raw_q[7:0];
        dec_q    = 8'd0;
        dec_q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            dec_q[i] = s1_raw_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    // Stage 2: tokens update rx_c; data is only passed while aligned
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            data_q <= 8'd0;
            c_q    <= 2'b00;
            dv_q   <= 1'b0;
        end else if (s1_ctrl_q) begin
            data_q <= 8'd0;
            c_q    <= s1_cval_q;
            dv_q   <= 1'b0;
        end else if (state_q == LOCKED) begin
            data_q <= dec_q;
            dv_q   <= 1'b1;
        end else begin
            data_q <= 8'd0;
            dv_q   <= 1'b0;
        end
    end

    // FSM and counter registers
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state_q <= SEARCH;
            run_q   <= '0;
            lock_q  <= '0;
            tmo_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            lock_q  <= lock_d;
            tmo_q   <= tmo_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic: run qualification, lock counting, timeout and slip sequencing
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        lock_d  = lock_q;
        tmo_d   = tmo_q;
        wait_d  = wait_q;

        // Saturating run of consecutive tokens; the event fires only on the
        // step into RUN_LEN, so a long run of tokens counts once.
        if (s1_ctrl_q) begin
            run_next = (run_q == RUN_FULL) ? run_q : run_q + RW'(1);
        end else begin
            run_next = '0;
        end
        run_event = s1_ctrl_q && (run_q == RUN_LAST);

        case (state_q)
            SEARCH: begin
                run_d = run_next;
                if (run_event) begin
                    // A qualified run wins over a coincident timeout
                    tmo_d  = '0;
                    lock_d = lock_q + LW'(1);
                    if (lock_q == LOCK_LAST) begin
                        state_d = LOCKED;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = SLIP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            SLIP: begin
                run_d   = '0;
                lock_d  = '0;
                tmo_d   = '0;
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // The deserializer output is unsettled here; keep the run empty
                run_d = '0;
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = SEARCH;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            LOCKED: begin
                run_d = run_next;
                if (run_event) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    // Lost lock: restart the search without shifting alignment
                    state_d = SEARCH;
                    run_d   = '0;
                    lock_d  = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = SEARCH;
        endcase
    end

`ifdef HDMI_RX_SLIPCNT_EN
    logic [15:0] slip_cnt_q;

    // Saturating count of bitslip pulses issued since reset
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            slip_cnt_q <= 16'd0;
        end else if (rx_bitslip && (slip_cnt_q != 16'hFFFF)) begin
            slip_cnt_q <= slip_cnt_q + 16'd1;
        end
    end

    assign rx_slip_cnt = slip_cnt_q;
`endif

    assign rx_bitslip  = (state_q == SLIP);
    assign rx_locked   = (state_q == LOCKED);
    assign rx_data     = data_q;
    assign rx_c        = c_q;
    assign rx_dv       = dv_q;
    assign dbg_state_o = state_q;

endmodule
